// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage and instruction memory.
//   imemAddr  : fetch address (master -> slave)
//   imemReq   : fetch request (master -> slave)
//   imemRdata : fetched word, valid when imemReq && imemReady (slave -> master)
//   imemReady : memory completes the request this cycle (slave -> master)
interface if_fetch_stage_if;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic [31:0] imemRdata;
  logic        imemReady;

  modport master (
    output imemAddr,
    output imemReq,
    input  imemRdata,
    input  imemReady
  );

  modport slave (
    input  imemAddr,
    input  imemReq,
    output imemRdata,
    output imemReady
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// It owns the PC and runs a req/ready handshake with instruction memory. It presents
// a registered instruction with its PC+PC_INC and a valid flag. A 1-entry skid buffer
// catches a word that completes while the output slot is stalled.
// Ports:
//   clk          : pipeline clock (rising edge)
//   resetN       : asynchronous active-low reset
//   imem         : instruction-memory bus (master side)
//   ifIdWr       : IF/ID accepts the presented word this cycle (0 = stall)
//   branchTaken  : taken-branch redirect from ID (wins over jump)
//   branchTarget : branch target address
//   jump         : jump redirect from ID
//   jumpTarget   : jump target address
//   instruction  : presented instruction (registered)
//   pcPlus4      : fetch address of presented instruction + PC_INC (registered)
//   fetchValid   : instruction/pcPlus4 hold an unconsumed word
//   ifIdFlush    : combinational squash of the IF/ID contents
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  if_fetch_stage_if.master        imem,
  input  logic                    ifIdWr,
  input  logic                    branchTaken,
  input  logic [31:0]             branchTarget,
  input  logic                    jump,
  input  logic [31:0]             jumpTarget,
  output logic [31:0]             instruction,
  output logic [31:0]             pcPlus4,
  output logic                    fetchValid,
  output logic                    ifIdFlush
);

  localparam logic [31:0] PcInc = 32'(PC_INC);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_fetch_valid;
  logic        r_skid_valid;
  logic [31:0] r_skid_data;
  logic [31:0] r_skid_pc4;
  logic [31:0] r_pend_target;

  state_e      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;
  logic [31:0] w_pc_plus4_next;
  logic        w_fetch_valid_next;
  logic        w_skid_valid_next;
  logic [31:0] w_skid_data_next;
  logic [31:0] w_skid_pc4_next;
  logic [31:0] w_pend_target_next;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_consume;
  logic [31:0] w_pc_inc;

  assign w_redirect = branchTaken | jump;
  assign w_target   = branchTaken ? branchTarget : jumpTarget;
  assign w_consume  = r_fetch_valid & ifIdWr;
  assign w_pc_inc   = r_pc + PcInc;

  // imemAddr only moves on a state change after completion, so it is stable while
  // a request is outstanding.
  assign imem.imemAddr = r_pc;
  assign imem.imemReq  = (r_state == StFetch) || (r_state == StDrain);
  assign ifIdFlush     = w_redirect && (r_state != StIdle);

  assign instruction = r_instr;
  assign pcPlus4     = r_pc_plus4;
  assign fetchValid  = r_fetch_valid;

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_instr_next       = r_instr;
    w_pc_plus4_next    = r_pc_plus4;
    w_fetch_valid_next = r_fetch_valid;
    w_skid_valid_next  = r_skid_valid;
    w_skid_data_next   = r_skid_data;
    w_skid_pc4_next    = r_skid_pc4;
    w_pend_target_next = r_pend_target;

    unique case (r_state)
      StIdle: begin
        w_state_next = StFetch;
      end
      StFetch: begin
        if (imem.imemReady) begin
          if (w_redirect) begin
            w_pc_next = w_target;
          end else if (!r_fetch_valid || w_consume) begin
            w_instr_next       = imem.imemRdata;
            w_pc_plus4_next    = w_pc_inc;
            w_fetch_valid_next = 1'b1;
            w_pc_next          = w_pc_inc;
          end else begin
            // Output slot stalled: park the word so it is not lost.
            w_skid_valid_next = 1'b1;
            w_skid_data_next  = imem.imemRdata;
            w_skid_pc4_next   = w_pc_inc;
            w_pc_next         = w_pc_inc;
            w_state_next      = StHold;
          end
        end else if (w_redirect) begin
          // Request must complete at the old address; remember where to go after.
          w_pend_target_next = w_target;
          w_state_next       = StDrain;
        end else if (w_consume) begin
          w_fetch_valid_next = 1'b0;
        end
      end
      StHold: begin
        if (w_redirect) begin
          w_skid_valid_next = 1'b0;
          w_pc_next         = w_target;
          w_state_next      = StFetch;
        end else if (w_consume) begin
          w_instr_next      = r_skid_data;
          w_pc_plus4_next   = r_skid_pc4;
          w_skid_valid_next = 1'b0;
          w_state_next      = StFetch;
        end
      end
      StDrain: begin
        if (imem.imemReady) begin
          w_pc_next    = w_redirect ? w_target : r_pend_target;
          w_state_next = StFetch;
        end else if (w_redirect) begin
          w_pend_target_next = w_target;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // A redirect squashes the presented word regardless of consume or capture.
    if (w_redirect && (r_state != StIdle)) begin
      w_fetch_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= StIdle;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_pc_plus4    <= 32'h0;
      r_fetch_valid <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_data   <= 32'h0;
      r_skid_pc4    <= 32'h0;
      r_pend_target <= 32'h0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_pc_plus4    <= w_pc_plus4_next;
      r_fetch_valid <= w_fetch_valid_next;
      r_skid_valid  <= w_skid_valid_next;
      r_skid_data   <= w_skid_data_next;
      r_skid_pc4    <= w_skid_pc4_next;
      r_pend_target <= w_pend_target_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with a combinational address-derived memory.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        resetN;
  logic        ifIdWr;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic [31:0] instruction;
  logic [31:0] pcPlus4;
  logic        fetchValid;
  logic        ifIdFlush;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage_if bus ();

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign bus.imemRdata = pat(bus.imemAddr);
  assign bus.imemReady = ready;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (4)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .imem         (bus),
    .ifIdWr       (ifIdWr),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .instruction  (instruction),
    .pcPlus4      (pcPlus4),
    .fetchValid   (fetchValid),
    .ifIdFlush    (ifIdFlush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] addr);
    chk({tag, ".valid"}, 32'(fetchValid), 32'd1);
    chk({tag, ".pc4"}, pcPlus4, addr + 32'd4);
    chk({tag, ".instr"}, instruction, pat(addr));
  endtask

  initial begin
    resetN = 1'b0; ifIdWr = 1'b1; ready = 1'b1;
    branchTaken = 1'b0; branchTarget = 32'h0; jump = 1'b0; jumpTarget = 32'h0;
    #12;
    chk("rst.valid", 32'(fetchValid), 32'd0);
    chk("rst.req", 32'(bus.imemReq), 32'd0);
    chk("rst.addr", bus.imemAddr, 32'h0);
    chk("rst.instr", instruction, 32'h0);
    chk("rst.pc4", pcPlus4, 32'h0);
    chk("rst.flush", 32'(ifIdFlush), 32'd0);

    // Sequential fetch: first valid on the 2nd edge after release.
    step();
    resetN = 1'b1;
    step();
    chk("e1.valid", 32'(fetchValid), 32'd0);
    chk("e1.req", 32'(bus.imemReq), 32'd1);
    step(); chk_word("seq0", 32'h0);
    step(); chk_word("seq4", 32'h4);
    step(); chk_word("seq8", 32'h8);

    // Stall 3 cycles with word @0x8 presented; @0xC goes to skid.
    ifIdWr = 1'b0;
    step();
    chk_word("stall1", 32'h8);
    chk("stall1.req", 32'(bus.imemReq), 32'd0);
    chk("stall1.addr", bus.imemAddr, 32'h10);
    step(); chk_word("stall2", 32'h8);
    step(); chk_word("stall3", 32'h8);
    ifIdWr = 1'b1;
    step(); chk_word("unstall.C", 32'hC);
    chk("unstall.req", 32'(bus.imemReq), 32'd1);
    step(); chk_word("unstall.10", 32'h10);

    // Branch with ready.
    branchTaken = 1'b1; branchTarget = 32'h100;
    #1; chk("br.flush", 32'(ifIdFlush), 32'd1);
    step();
    branchTaken = 1'b0;
    chk("br.valid", 32'(fetchValid), 32'd0);
    chk("br.addr", bus.imemAddr, 32'h100);
    step(); chk_word("br.100", 32'h100);

    // Jump while memory waits.
    ready = 1'b0;
    step();
    chk("wait.valid", 32'(fetchValid), 32'd0);
    chk("wait.addr1", bus.imemAddr, 32'h104);
    jump = 1'b1; jumpTarget = 32'h200;
    #1; chk("wait.flush", 32'(ifIdFlush), 32'd1);
    step();
    jump = 1'b0;
    chk("drain.addr2", bus.imemAddr, 32'h104);
    chk("drain.req2", 32'(bus.imemReq), 32'd1);
    step(); chk("drain.addr3", bus.imemAddr, 32'h104);
    step(); chk("drain.addr4", bus.imemAddr, 32'h104);
    ready = 1'b1;
    step();
    chk("drain.addr", bus.imemAddr, 32'h200);
    chk("drain.valid", 32'(fetchValid), 32'd0);
    step(); chk_word("j.200", 32'h200);

    // Simultaneous branch and jump: branch wins.
    branchTaken = 1'b1; branchTarget = 32'h300; jump = 1'b1; jumpTarget = 32'h400;
    step();
    branchTaken = 1'b0; jump = 1'b0;
    chk("prio.addr", bus.imemAddr, 32'h300);
    chk("prio.valid", 32'(fetchValid), 32'd0);
    step(); chk_word("prio.300", 32'h300);

    // Redirect in HOLD discards the skid.
    ifIdWr = 1'b0;
    step();
    chk("hold.req", 32'(bus.imemReq), 32'd0);
    chk("hold.addr", bus.imemAddr, 32'h308);
    jump = 1'b1; jumpTarget = 32'h400;
    #1; chk("hold.flush", 32'(ifIdFlush), 32'd1);
    step();
    jump = 1'b0; ifIdWr = 1'b1;
    chk("hold.valid", 32'(fetchValid), 32'd0);
    chk("hold.tgt", bus.imemAddr, 32'h400);
    step(); chk_word("hold.400", 32'h400);

    // Reset asserted while in DRAIN.
    ready = 1'b0;
    jump = 1'b1; jumpTarget = 32'h500;
    step();
    jump = 1'b0;
    chk("d.req", 32'(bus.imemReq), 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("drst.req", 32'(bus.imemReq), 32'd0);
    chk("drst.valid", 32'(fetchValid), 32'd0);
    chk("drst.addr", bus.imemAddr, 32'h0);
    ready = 1'b1;
    step();
    resetN = 1'b1;
    // Redirects are ignored in IDLE.
    jump = 1'b1; jumpTarget = 32'h700;
    #1; chk("idle.flush", 32'(ifIdFlush), 32'd0);
    step();
    jump = 1'b0;
    chk("idle.addr", bus.imemAddr, 32'h0);
    chk("idle.valid", 32'(fetchValid), 32'd0);
    step(); chk_word("rr.0", 32'h0);

    // PC wrap at the top of the address space.
    jump = 1'b1; jumpTarget = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    chk("wrap.addr", bus.imemAddr, 32'hFFFF_FFFC);
    step();
    chk("wrap.pc4", pcPlus4, 32'h0);
    chk("wrap.instr", instruction, pat(32'hFFFF_FFFC));
    chk("wrap.next", bus.imemAddr, 32'h0);
    step(); chk_word("wrap.0", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and runs a req/ready handshake with instruction memory. It presents a registered instruction and its PC+4 with a valid flag, and a flush pulse for the IF/ID register. It honours the hazard unit's IF/ID write enable (stall) and branch/jump redirects from ID, using a 1-entry skid buffer so that no fetched word is lost.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, byte increment per sequential fetch.

Ports:
clk  input  1  pipeline clock; all state changes on its rising edge.
resetN  input  1  asynchronous, active-low reset.
ifIdWr  input  1  downstream IF/ID register accepts the presented word this cycle; 0 = stall.
branchTaken  input  1  ID-stage taken-branch redirect.
branchTarget  input  32  branch target address.
jump  input  1  ID-stage jump redirect.
jumpTarget  input  32  jump target address.
imemAddr  output  32  fetch address.
imemReq  output  1  fetch request.
imemRdata  input  32  fetched word; valid when imemReq && imemReady.
imemReady  input  1  memory completes the request this cycle.
instruction  output  32  presented instruction (registered).
pcPlus4  output  32  fetch address of the presented instruction + PC_INC (registered).
fetchValid  output  1  instruction/pcPlus4 hold an unconsumed fetched word.
ifIdFlush  output  1  combinational; squashes the IF/ID contents this cycle.

Behaviour:
- Reset (resetN=0, asynchronous, any state): pc=RESET_PC, state=IDLE, instruction=0, pcPlus4=0, fetchValid=0, skid valid=0, skid data=0, pendTarget=0. imemReq=0 and ifIdFlush=0 while in reset. Reset mid-handshake abandons the request with no further effect.
- Definitions:
  - redirect = branchTaken | jump.
  - target = branchTaken ? branchTarget : jumpTarget. Branch has priority over jump.
  - consume = fetchValid & ifIdWr.
  - ifIdFlush = redirect, in every state except IDLE.
- Any redirect clears fetchValid at the edge, overriding consume and capture.
- imemAddr = pc in all states; imemReq = 1 in FETCH and DRAIN only.
- Handshake rule: once imemReq is high, imemReq and imemAddr stay stable until imemReady.
- IDLE: no request; next edge goes to FETCH. Redirects are ignored in IDLE.
- FETCH:
  - imemReady=1, redirect=1: drop the word; pc<=target; stay in FETCH.
  - imemReady=1, no redirect, output slot free (fetchValid=0 or consume=1): instruction<=imemRdata; pcPlus4<=pc+PC_INC; fetchValid<=1; pc<=pc+PC_INC.
  - imemReady=1, no redirect, slot full and not consumed: skid<=word and pc+PC_INC; pc<=pc+PC_INC; go to HOLD.
  - imemReady=0, redirect=1: pendTarget<=target; go to DRAIN.
  - imemReady=0, no redirect: if consume, fetchValid<=0.
- HOLD:
  - imemReq=0.
  - redirect: discard skid; pc<=target; go to FETCH.
  - else, consume: skid moves into instruction/pcPlus4; fetchValid stays 1; go to FETCH.
  - else: hold all state.
- DRAIN:
  - imemReq=1 at the old pc.
  - A redirect during DRAIN overwrites pendTarget (latest wins).
  - On imemReady: discard the word; pc<=redirect ? target : pendTarget; go to FETCH.
  - consume is irrelevant here because fetchValid is already 0.
- Arithmetic: pc+PC_INC is a 32-bit add; wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag. Targets are used unaligned-as-given (no masking).
- Latency: zero-wait memory (imemReady tied 1) with no stalls delivers one word per cycle. The first fetchValid=1 occurs 2 rising edges after resetN deasserts.
- No word is ever duplicated or skipped without a redirect.

Test Plan:
- Reset, imemReady=1, imemRdata=addr-derived pattern, ifIdWr=1 -> fetchValid rises on the 2nd edge; the pcPlus4 sequence is 0x4, 0x8, 0xC… with instruction matching each address.
- Stall: hold ifIdWr=0 for 3 cycles after word @0x8 is presented -> skid captures @0xC, imemReq drops, and instruction stays @0x8. Then ifIdWr=1 -> @0xC and @0x10 follow back-to-back with no loss or duplicate.
- Branch with ready: branchTaken=1, branchTarget=0x100 in FETCH -> ifIdFlush=1 that cycle, fetchValid=0 next, and the next presented pcPlus4 is 0x104.
- Branch during wait: imemReady=0 for 4 cycles, then jump=1, jumpTarget=0x200 at cycle 2 -> imemAddr stays at the old pc until ready, the word is discarded, and the next imemAddr is 0x200.
- Simultaneous branchTaken=1 (0x300) and jump=1 (0x400) -> pc=0x300. A redirect while in HOLD discards the skid and the next fetch is at the target.
- Assert resetN=0 while in DRAIN -> immediately imemReq=0, fetchValid=0, pc=RESET_PC; after release, a normal fetch from 0x0.
